subbytes_iter: RTL and testbench
================================

SUBBYTES_ITER -- requirements
Module: subbytes_iter

Interface
REQ-001 SHALL have parameter SBOX_LANES, default 4: number of S-box lanes (bytes substituted per cycle); legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have parameter BLOCK_WIDTH, default 128: state width in bits; fixed at 128; any other value is a compile-time error.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port i_clk, input, 1 bit: clock, rising edge.
REQ-005 SHALL have port i_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port i_valid, input, 1 bit: input block valid.
REQ-007 SHALL have port o_ready, output, 1 bit: block can accept input.
REQ-008 SHALL have port i_inv, input, 1 bit: 0 = forward S-box, 1 = inverse S-box; sampled on accept.
REQ-009 SHALL have port i_data, input, 128 bits: state; byte k = bits [8k+7:8k].
REQ-010 SHALL have port o_valid, output, 1 bit: result valid.
REQ-011 SHALL have port i_ready, input, 1 bit: downstream accepts the result.
REQ-012 SHALL have port o_data, output, 128 bits: substituted state, same byte mapping as i_data.
REQ-013 SHALL have port i_flush, input, 1 bit: synchronous abort.
REQ-014 SHALL have port o_busy, output, 1 bit: high in BUSY.

Function
REQ-015 SHALL implement states IDLE, BUSY and DONE; BEATS = 16/SBOX_LANES.
REQ-016 SHALL have o_ready = 1 only in IDLE; accept = i_valid && o_ready at a rising edge.
REQ-017 On accept, SHALL latch i_data and i_inv, clear the beat counter to 0, and move to BUSY.
REQ-018 In BUSY, beat b SHALL replace bytes b*SBOX_LANES .. b*SBOX_LANES+SBOX_LANES-1 of the held state with their S-box (or inverse S-box) values, then increment b.
REQ-019 On beat BEATS-1, SHALL move to DONE; o_valid SHALL rise exactly BEATS cycles after the accept edge (SBOX_LANES=16: 1 cycle).
REQ-020 In DONE, o_valid = 1 and o_data SHALL be stable until an edge with i_ready = 1, which moves to IDLE; there is no same-cycle re-accept.
REQ-021 o_data SHALL be driven from a register only, with no combinational path from any input.
REQ-022 i_data and i_inv changes after accept SHALL NOT affect the block in flight.
REQ-023 i_flush = 1 SHALL move any state to IDLE on the next edge, clear the counter and o_valid, and keep o_data unchanged; flush has priority over accept and i_ready.
REQ-024 i_valid in BUSY or DONE SHALL be ignored, with no queuing.
REQ-025 The beat counter SHALL be $clog2(BEATS) bits wide (minimum 1 bit) and SHALL never exceed BEATS-1.

Reset
REQ-026 Asserting i_rst_n = 0 SHALL immediately force IDLE, counter 0, o_valid 0, o_busy 0, o_data 128'h0 and inverse flag 0.
REQ-027 Reset mid-operation SHALL discard the block in flight; the first accept after release SHALL behave as after power-up.
REQ-028 o_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-029 Shared package aes_pkg SHALL hold: AES_BLOCK_W = 128, AES_BYTE_W = 8, AES_NUM_BYTES = 16, and the state enum typedef.
REQ-030 Sub-module aes_sbox SHALL be combinational, 8-bit in and 8-bit out, with an inv select; it is instantiated SBOX_LANES times via generate.
REQ-031 Lane inputs SHALL be muxed by beat index from the held state; no full 16-S-box array unless SBOX_LANES = 16.

Verification
REQ-032 SHALL cover, with SBOX_LANES=4, i_inv=0: i_data=128'h193de3bea0f4e22b9ac68d2ae9f84808 -> o_data=128'hd42711aee0bf98f1b8b45de51e415230, with o_valid exactly 4 cycles after accept.
REQ-033 SHALL cover, with i_inv=1 and the output of REQ-032 as input -> o_data=128'h193de3bea0f4e22b9ac68d2ae9f84808.
REQ-034 SHALL cover all 5 legal SBOX_LANES values with i_data=128'h0 -> o_data=128'h6363...63 (all bytes 0x63), latency 16/8/4/2/1 cycles.
REQ-035 SHALL cover backpressure: i_ready held 0 for 10 cycles in DONE -> o_valid=1, o_data stable, o_ready=0, and a new i_valid ignored.
REQ-036 SHALL cover i_flush in beat 2 -> IDLE next cycle, o_valid never asserted; the next block 128'h53... (byte 0x53) -> 0xED per byte.
REQ-037 SHALL cover i_rst_n asserted mid-BUSY -> all outputs at reset values asynchronously; the next accept completes correctly.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: block geometry, control state encoding and the
// GF(2^8) arithmetic behind the S-box.
package aes_pkg;

   localparam int AES_BLOCK_W   = 128;
   localparam int AES_BYTE_W    = 8;
   localparam int AES_NUM_BYTES = 16;

   localparam logic [7:0] AES_AFFINE_C     = 8'h63;
   localparam logic [7:0] AES_INV_AFFINE_C = 8'h05;
   localparam logic [7:0] AES_POLY_LOW     = 8'h1b;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } aes_state_e;

   function automatic logic [7:0] gf_xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY_LOW : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         p = p ^ (t & {8{b[i]}});
         t = gf_xtime(t);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse for a != 0 and maps 0 to 0
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] t;
      r = 8'h01;
      t = a;
      for (int i = 1; i < 8; i++) begin
         t = gf_mul(t, t);
         r = gf_mul(r, t);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   function automatic logic [7:0] aes_affine(input logic [7:0] x);
      return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ AES_AFFINE_C;
   endfunction

   function automatic logic [7:0] aes_inv_affine(input logic [7:0] s);
      return rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ AES_INV_AFFINE_C;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES byte substitution; i_inv selects the inverse S-box.
// Both directions share one field inverter.
module aes_sbox
   import aes_pkg::*;
(
   input  logic       i_inv,
   input  logic [7:0] i_data,
   output logic [7:0] o_data
);

   logic [7:0] pre_s;
   logic [7:0] ginv_s;

   // Forward: affine(inv(x)); inverse: inv(inv_affine(x))
   always_comb begin
      pre_s  = 8'h00;
      ginv_s = 8'h00;
      o_data = 8'h00;
      if (i_inv) begin
         pre_s = aes_inv_affine(i_data);
      end else begin
         pre_s = i_data;
      end
      ginv_s = gf_inv(pre_s);
      if (i_inv) begin
         o_data = ginv_s;
      end else begin
         o_data = aes_affine(ginv_s);
      end
   end

endmodule

// File: rtl/subbytes_iter.sv
// Iterative AES SubBytes: substitutes SBOX_LANES bytes of the held state per
// cycle and presents the finished state through a valid/ready handshake.
module subbytes_iter
   import aes_pkg::*;
#(
   parameter int SBOX_LANES  = 4,
   parameter int BLOCK_WIDTH = 128
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_valid,
   output logic                   o_ready,
   input  logic                   i_inv,
   input  logic [AES_BLOCK_W-1:0] i_data,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [AES_BLOCK_W-1:0] o_data,
   input  logic                   i_flush,
   output logic                   o_busy
);

   localparam int BEATS = AES_NUM_BYTES / SBOX_LANES;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   generate
      if (BLOCK_WIDTH != AES_BLOCK_W) begin : g_bad_width
         $error("subbytes_iter: BLOCK_WIDTH must be 128");
      end
      if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4 &&
          SBOX_LANES != 8 && SBOX_LANES != 16) begin : g_bad_lanes
         $error("subbytes_iter: SBOX_LANES must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   aes_state_e             state_r;
   logic [CNT_W-1:0]       beat_r;
   logic                   inv_r;
   logic [AES_BLOCK_W-1:0] data_r;
   logic [AES_BLOCK_W-1:0] out_r;
   logic                   valid_r;
   logic                   ready_r;
   logic                   busy_r;

   logic [3:0]             lane_idx_s [SBOX_LANES];
   logic [7:0]             lane_in_s  [SBOX_LANES];
   logic [7:0]             lane_out_s [SBOX_LANES];
   logic [AES_BLOCK_W-1:0] next_data_s;

   // Lane j of beat b works on byte b*SBOX_LANES+j of the held state
   generate
      for (genvar j = 0; j < SBOX_LANES; j++) begin : g_lane
         assign lane_idx_s[j] = 4'(int'(beat_r) * SBOX_LANES + j);
         assign lane_in_s[j]  = data_r[{lane_idx_s[j], 3'b000} +: AES_BYTE_W];

         aes_sbox u_sbox (
            .i_inv  (inv_r),
            .i_data (lane_in_s[j]),
            .o_data (lane_out_s[j])
         );
      end
   endgenerate

   // Held state with the current beat's bytes replaced
   always_comb begin
      next_data_s = data_r;
      for (int j = 0; j < SBOX_LANES; j++) begin
         next_data_s[{lane_idx_s[j], 3'b000} +: AES_BYTE_W] = lane_out_s[j];
      end
   end

   // Control FSM with the held state, result register and status outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r <= ST_IDLE;
         beat_r  <= '0;
         inv_r   <= 1'b0;
         data_r  <= '0;
         out_r   <= '0;
         valid_r <= 1'b0;
         ready_r <= 1'b1;
         busy_r  <= 1'b0;
      end else if (i_flush) begin
         // Abort leaves the last published result in place
         state_r <= ST_IDLE;
         beat_r  <= '0;
         valid_r <= 1'b0;
         ready_r <= 1'b1;
         busy_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (i_valid) begin
                  data_r  <= i_data;
                  inv_r   <= i_inv;
                  beat_r  <= '0;
                  state_r <= ST_BUSY;
                  ready_r <= 1'b0;
                  busy_r  <= 1'b1;
               end else begin
                  ready_r <= 1'b1;
               end
            end
            ST_BUSY: begin
               data_r <= next_data_s;
               if (beat_r == LAST_BEAT) begin
                  out_r   <= next_data_s;
                  beat_r  <= '0;
                  state_r <= ST_DONE;
                  valid_r <= 1'b1;
                  busy_r  <= 1'b0;
               end else begin
                  beat_r <= beat_r + CNT_W'(1);
               end
            end
            ST_DONE: begin
               if (i_ready) begin
                  state_r <= ST_IDLE;
                  valid_r <= 1'b0;
                  ready_r <= 1'b1;
               end else begin
                  valid_r <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               beat_r  <= '0;
               valid_r <= 1'b0;
               ready_r <= 1'b1;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign o_ready = ready_r;
   assign o_valid = valid_r;
   assign o_busy  = busy_r;
   assign o_data  = out_r;

endmodule

// File: tb/tb_subbytes_iter.sv
// Self-checking bench: all five lane widths run side by side on shared inputs
// and are compared against an algebraic S-box model built at start-up.
module tb_subbytes_iter;

   localparam int NDUT = 5;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         i_valid;
   logic         i_inv;
   logic         i_ready;
   logic         i_flush;
   logic [127:0] i_data;
   logic         o_ready [NDUT];
   logic         o_valid [NDUT];
   logic         o_busy  [NDUT];
   logic [127:0] o_data  [NDUT];

   int           n_checks = 0;
   int           n_fail   = 0;
   logic [7:0]   fwd_tab [256];
   logic [7:0]   inv_tab [256];

   always #5 clk = ~clk;

   generate
      for (genvar k = 0; k < NDUT; k++) begin : g_dut
         subbytes_iter #(.SBOX_LANES(1 << k), .BLOCK_WIDTH(128)) u_dut (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .i_valid (i_valid),
            .o_ready (o_ready[k]),
            .i_inv   (i_inv),
            .i_data  (i_data),
            .o_valid (o_valid[k]),
            .i_ready (i_ready),
            .o_data  (o_data[k]),
            .i_flush (i_flush),
            .o_busy  (o_busy[k])
         );
      end
   endgenerate

   // Polynomial product followed by long division by x^8+x^4+x^3+x+1
   function automatic logic [7:0] gmul_ref(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
      for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] affine_ref(input logic [7:0] x);
      logic [7:0] c;
      logic [7:0] b;
      c = 8'h63;
      for (int i = 0; i < 8; i++)
         b[i] = x[i] ^ x[(i + 4) % 8] ^ x[(i + 5) % 8] ^ x[(i + 6) % 8] ^ x[(i + 7) % 8] ^ c[i];
      return b;
   endfunction

   function automatic logic [127:0] sub_ref(input logic [127:0] d, input logic inv);
      logic [127:0] r;
      logic [7:0]   b;
      r = '0;
      for (int k = 0; k < 16; k++) begin
         b = d[8*k +: 8];
         r[8*k +: 8] = inv ? inv_tab[b] : fwd_tab[b];
      end
      return r;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic accept(input logic [127:0] d, input logic inv);
      @(posedge clk); #1;
      i_valid = 1'b1;
      i_data  = d;
      i_inv   = inv;
      @(posedge clk); #1;
      i_valid = 1'b0;
      i_data  = rand128();
      i_inv   = ~inv;
   endtask

   // One block through every DUT with i_ready high; checks data and latency
   task automatic run_block(input logic [127:0] d, input logic inv, input string tag);
      logic [127:0] exp;
      bit           seen [NDUT];
      exp = sub_ref(d, inv);
      for (int k = 0; k < NDUT; k++) seen[k] = 1'b0;
      i_ready = 1'b1;
      accept(d, inv);
      for (int k = 0; k < NDUT; k++) begin
         chk($sformatf("%s busy L%0d", tag, 1 << k), 128'(o_busy[k]), 128'd1);
         chk($sformatf("%s ready L%0d", tag, 1 << k), 128'(o_ready[k]), 128'd0);
      end
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(posedge clk); #1;
         for (int k = 0; k < NDUT; k++) begin
            if (!seen[k] && o_valid[k]) begin
               seen[k] = 1'b1;
               chk($sformatf("%s latency L%0d", tag, 1 << k), 128'(cyc), 128'(16 >> k));
               chk($sformatf("%s data L%0d", tag, 1 << k), o_data[k], exp);
            end
         end
      end
      for (int k = 0; k < NDUT; k++) begin
         chk($sformatf("%s completed L%0d", tag, 1 << k), 128'(seen[k]), 128'd1);
         chk($sformatf("%s idle ready L%0d", tag, 1 << k), 128'(o_ready[k]), 128'd1);
      end
   endtask

   initial begin
      logic [127:0] d;
      logic [127:0] exp;
      logic [127:0] prev [NDUT];
      logic         inv;

      for (int x = 0; x < 256; x++) begin
         logic [7:0] y;
         y = 8'h00;
         for (int c = 1; c < 256; c++)
            if (gmul_ref(8'(x), 8'(c)) == 8'h01) y = 8'(c);
         fwd_tab[x] = affine_ref(y);
      end
      for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);

      rst_n   = 1'b0;
      i_valid = 1'b0;
      i_inv   = 1'b0;
      i_ready = 1'b1;
      i_flush = 1'b0;
      i_data  = '0;
      #12;
      for (int k = 0; k < NDUT; k++) begin
         chk("reset valid", 128'(o_valid[k]), 128'd0);
         chk("reset busy", 128'(o_busy[k]), 128'd0);
         chk("reset data", o_data[k], 128'h0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < NDUT; k++) chk("ready after reset", 128'(o_ready[k]), 128'd1);

      run_block(128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, "fips fwd");
      chk("fips fwd const", o_data[2], 128'hd42711aee0bf98f1b8b45de51e415230);
      run_block(128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, "fips inv");
      chk("fips inv const", o_data[2], 128'h193de3bea0f4e22b9ac68d2ae9f84808);
      run_block(128'h0, 1'b0, "zero");
      for (int k = 0; k < NDUT; k++) chk("zero const", o_data[k], {16{8'h63}});

      for (int n = 0; n < 6; n++) begin
         d   = rand128();
         inv = 1'($urandom_range(1, 0));
         run_block(d, inv, $sformatf("rand%0d", n));
      end

      // Backpressure: result held, further i_valid ignored
      d   = rand128();
      exp = sub_ref(d, 1'b0);
      i_ready = 1'b0;
      accept(d, 1'b0);
      repeat (16) @(posedge clk);
      #1;
      for (int c = 0; c < 10; c++) begin
         i_valid = 1'b1;
         i_data  = rand128();
         @(posedge clk); #1;
         for (int k = 0; k < NDUT; k++) begin
            chk("bp valid", 128'(o_valid[k]), 128'd1);
            chk("bp data", o_data[k], exp);
            chk("bp ready", 128'(o_ready[k]), 128'd0);
         end
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < NDUT; k++) begin
         chk("bp release valid", 128'(o_valid[k]), 128'd0);
         chk("bp release ready", 128'(o_ready[k]), 128'd1);
      end
      @(posedge clk); #1;
      for (int k = 0; k < NDUT; k++) chk("bp no queue", 128'(o_busy[k]), 128'd0);

      // Flush during beat 2 of the 4-lane instance
      for (int k = 0; k < NDUT; k++) prev[k] = o_data[k];
      accept(rand128(), 1'b0);
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) chk("flush early valid", 128'(o_valid[k]), 128'd0);
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) chk("flush early valid", 128'(o_valid[k]), 128'd0);
      i_flush = 1'b1;
      @(posedge clk); #1;
      i_flush = 1'b0;
      for (int k = 0; k < NDUT; k++) begin
         chk("flush ready", 128'(o_ready[k]), 128'd1);
         chk("flush valid", 128'(o_valid[k]), 128'd0);
         chk("flush busy", 128'(o_busy[k]), 128'd0);
      end
      for (int k = 0; k < 3; k++) chk("flush data kept", o_data[k], prev[k]);
      repeat (3) begin
         @(posedge clk); #1;
         chk("flush no valid", 128'(o_valid[2]), 128'd0);
      end
      run_block({16{8'h53}}, 1'b0, "after flush");
      chk("after flush const", o_data[2], {16{8'hed}});

      // Asynchronous reset in the middle of a block
      accept(rand128(), 1'b1);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < NDUT; k++) begin
         chk("async rst valid", 128'(o_valid[k]), 128'd0);
         chk("async rst busy", 128'(o_busy[k]), 128'd0);
         chk("async rst data", o_data[k], 128'h0);
      end
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < NDUT; k++) chk("rst release ready", 128'(o_ready[k]), 128'd1);
      run_block(rand128(), 1'b0, "after rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
